// File: rtl/snake_body_tracker.sv
// Ordered snake body store: advances one tile per step pulse, scans the body
// sequentially for self collision and latches wall or self hits into game_done.
module snake_body_tracker #(
    parameter int MAX_LEN   = 100,
    parameter int GRID_W    = 10,
    parameter int GRID_H    = 10,
    parameter int START_X   = 4,
    parameter int START_Y   = 4,
    parameter int START_LEN = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   step,
    input  logic [1:0]             dir,
    input  logic                   grow,
    input  logic                   restart,
    output logic [32*MAX_LEN-1:0]  x_values,
    output logic [32*MAX_LEN-1:0]  y_values,
    output logic [31:0]            head_x,
    output logic [31:0]            head_y,
    output logic [31:0]            length,
    output logic                   busy,
    output logic                   step_done,
    output logic                   game_done
);

    localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    typedef enum logic [1:0] {IDLE, SCAN, COMMIT, DEAD} state_t;

    state_t                    state;
    logic        [1:0]         cur_dir;
    logic                      grow_pend;
    logic        [31:0]        seg_x [MAX_LEN];
    logic        [31:0]        seg_y [MAX_LEN];
    logic        [31:0]        nh_x;
    logic        [31:0]        nh_y;
    logic        [IDX_W-1:0]   scan_idx;
    logic        [IDX_W-1:0]   last_idx;

    logic        [1:0]         dir_eff;
    logic signed [31:0]        cand_x;
    logic signed [31:0]        cand_y;
    logic                      wall_hit;
    logic                      scan_hit;
    logic                      keep_tail;
    logic                      l_eff_zero;

    function automatic logic [31:0] init_x(input int k);
        return (k < START_LEN) ? 32'(START_X - k) : '1;
    endfunction

    function automatic logic [31:0] init_y(input int k);
        return (k < START_LEN) ? 32'(START_Y) : '1;
    endfunction

    function automatic logic signed [31:0] step_dx(input logic [1:0] d);
        case (d)
            2'd1:    return 32'sd1;
            2'd3:    return -32'sd1;
            default: return 32'sd0;
        endcase
    endfunction

    function automatic logic signed [31:0] step_dy(input logic [1:0] d);
        case (d)
            2'd0:    return -32'sd1;
            2'd2:    return 32'sd1;
            default: return 32'sd0;
        endcase
    endfunction

    // A request for the exact opposite heading is a reversal and keeps the current heading.
    always_comb begin
        dir_eff    = (dir == (cur_dir ^ 2'd2)) ? cur_dir : dir;
        cand_x     = $signed(seg_x[0]) + step_dx(dir_eff);
        cand_y     = $signed(seg_y[0]) + step_dy(dir_eff);
        wall_hit   = (cand_x < 0) || (cand_x >= GRID_W) ||
                     (cand_y < 0) || (cand_y >= GRID_H);
        scan_hit   = (seg_x[scan_idx] == nh_x) && (seg_y[scan_idx] == nh_y);
        keep_tail  = grow_pend && (length < 32'(MAX_LEN));
        l_eff_zero = !grow_pend && (length == 32'd1);
    end

    for (genvar k = 0; k < MAX_LEN; k++) begin : g_pack
        assign x_values[32*k +: 32] = seg_x[k];
        assign y_values[32*k +: 32] = seg_y[k];
    end

    assign head_x = seg_x[0];
    assign head_y = seg_y[0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cur_dir   <= 2'd1;
            grow_pend <= 1'b0;
            length    <= 32'(START_LEN);
            busy      <= 1'b0;
            step_done <= 1'b0;
            game_done <= 1'b0;
            nh_x      <= '0;
            nh_y      <= '0;
            scan_idx  <= '0;
            last_idx  <= '0;
            for (int k = 0; k < MAX_LEN; k++) begin
                seg_x[k] <= init_x(k);
                seg_y[k] <= init_y(k);
            end
        end else if (restart) begin
            state     <= IDLE;
            cur_dir   <= 2'd1;
            grow_pend <= 1'b0;
            length    <= 32'(START_LEN);
            busy      <= 1'b0;
            step_done <= 1'b0;
            game_done <= 1'b0;
            scan_idx  <= '0;
            for (int k = 0; k < MAX_LEN; k++) begin
                seg_x[k] <= init_x(k);
                seg_y[k] <= init_y(k);
            end
        end else begin
            step_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (step) begin
                        cur_dir  <= dir_eff;
                        nh_x     <= cand_x;
                        nh_y     <= cand_y;
                        scan_idx <= '0;
                        // The tail slot is only a collision target when it stays put (growing).
                        last_idx <= IDX_W'(grow_pend ? length - 32'd1 : length - 32'd2);
                        if (wall_hit) begin
                            state     <= DEAD;
                            game_done <= 1'b1;
                        end else begin
                            state <= l_eff_zero ? COMMIT : SCAN;
                            busy  <= 1'b1;
                        end
                    end
                end
                SCAN: begin
                    if (scan_hit) begin
                        state     <= DEAD;
                        busy      <= 1'b0;
                        game_done <= 1'b1;
                    end else if (scan_idx == last_idx) begin
                        state <= COMMIT;
                    end else begin
                        scan_idx <= scan_idx + 1'b1;
                    end
                end
                COMMIT: begin
                    for (int k = 1; k < MAX_LEN; k++) begin
                        seg_x[k] <= (!keep_tail && length == 32'(k)) ? '1 : seg_x[k-1];
                        seg_y[k] <= (!keep_tail && length == 32'(k)) ? '1 : seg_y[k-1];
                    end
                    seg_x[0]  <= nh_x;
                    seg_y[0]  <= nh_y;
                    if (keep_tail)
                        length <= length + 32'd1;
                    grow_pend <= 1'b0;
                    step_done <= 1'b1;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                end
            endcase
            // Placed last so a grow pulse beats COMMIT's clear; a full body drops the request.
            if (grow && state != DEAD)
                grow_pend <= (length < 32'(MAX_LEN));
        end
    end

endmodule

// File: tb/tb_snake_body_tracker.sv
// Randomised and directed bench for snake_body_tracker against a queue-based
// model of the body list, move latency and collision rules.
module tb_snake_body_tracker;

    localparam int MAX_LEN   = 100;
    localparam int GRID_W    = 10;
    localparam int GRID_H    = 10;
    localparam int START_X   = 4;
    localparam int START_Y   = 4;
    localparam int START_LEN = 2;
    localparam int BUS       = 32 * MAX_LEN;

    logic            clk = 1'b0;
    logic            reset, step, grow, restart;
    logic [1:0]      dir;
    logic [BUS-1:0]  x_values, y_values;
    logic [31:0]     head_x, head_y, length;
    logic            busy, step_done, game_done;

    int checks, passed;

    int         mq_x[$];
    int         mq_y[$];
    logic [1:0] m_dir;
    bit         m_grow, m_dead;

    snake_body_tracker #(
        .MAX_LEN(MAX_LEN), .GRID_W(GRID_W), .GRID_H(GRID_H),
        .START_X(START_X), .START_Y(START_Y), .START_LEN(START_LEN)
    ) dut (
        .clk(clk), .reset(reset), .step(step), .dir(dir), .grow(grow),
        .restart(restart), .x_values(x_values), .y_values(y_values),
        .head_x(head_x), .head_y(head_y), .length(length), .busy(busy),
        .step_done(step_done), .game_done(game_done)
    );

    always #5 clk = ~clk;

    task automatic model_init();
        mq_x.delete();
        mq_y.delete();
        for (int k = 0; k < START_LEN; k++) begin
            mq_x.push_back(START_X - k);
            mq_y.push_back(START_Y);
        end
        m_dir  = 2'd1;
        m_grow = 1'b0;
        m_dead = 1'b0;
    endtask

    function automatic logic [BUS-1:0] exp_bus(input bit is_x);
        logic [BUS-1:0] b;
        b = '1;
        for (int k = 0; k < mq_x.size(); k++)
            b[32*k +: 32] = is_x ? mq_x[k] : mq_y[k];
        return b;
    endfunction

    // outcome: 0 commit, 1 collision, 2 ignored (already dead); lat = edges after E0
    task automatic model_step(input logic [1:0] d, output int outcome, output int lat);
        int nx, ny, leff, hit;
        bit keep;
        if (m_dead) begin
            outcome = 2; lat = 0;
            return;
        end
        if (d != (m_dir ^ 2'd2)) m_dir = d;
        nx = mq_x[0]; ny = mq_y[0];
        case (m_dir)
            2'd0: ny = ny - 1;
            2'd1: nx = nx + 1;
            2'd2: ny = ny + 1;
            default: nx = nx - 1;
        endcase
        if (nx < 0 || nx >= GRID_W || ny < 0 || ny >= GRID_H) begin
            m_dead = 1'b1; outcome = 1; lat = 0;
            return;
        end
        leff = m_grow ? mq_x.size() : mq_x.size() - 1;
        hit = -1;
        for (int i = 0; i < leff; i++)
            if (hit < 0 && mq_x[i] == nx && mq_y[i] == ny) hit = i;
        if (hit >= 0) begin
            m_dead = 1'b1; outcome = 1; lat = hit + 1;
            return;
        end
        keep = m_grow && (mq_x.size() < MAX_LEN);
        mq_x.push_front(nx);
        mq_y.push_front(ny);
        if (!keep) begin
            void'(mq_x.pop_back());
            void'(mq_y.pop_back());
        end
        m_grow = 1'b0;
        outcome = 0; lat = leff + 1;
    endtask

    task automatic pulse_grow();
        @(negedge clk); grow = 1'b1;
        @(negedge clk); grow = 1'b0;
        if (!m_dead) m_grow = (mq_x.size() < MAX_LEN);
    endtask

    task automatic do_restart();
        @(negedge clk); restart = 1'b1;
        @(negedge clk); restart = 1'b0;
        model_init();
    endtask

    // Drives one step pulse and measures edges after E0 until step_done/game_done.
    task automatic do_move(input logic [1:0] d, output int outcome, output int lat,
                           output int obs, output logic busy0);
        model_step(d, outcome, lat);
        @(negedge clk); dir = d; step = 1'b1;
        @(negedge clk); step = 1'b0; busy0 = busy;
        obs = -1;
        for (int k = 0; k <= MAX_LEN + 4; k++) begin
            if (step_done || game_done) begin
                obs = k;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        @(negedge clk); reset = 1'b1;
        #2;
        model_init();
        checks++; if (x_values !== exp_bus(1)) $display("FAIL reset_x: got %h required %h", x_values[63:0], exp_bus(1)); else passed++;
        checks++; if (y_values !== exp_bus(0)) $display("FAIL reset_y: got %h required %h", y_values[63:0], exp_bus(0)); else passed++;
        checks++; if (length !== 32'd2) $display("FAIL reset_length: got %0d required 2", length); else passed++;
        checks++; if (game_done !== 1'b0) $display("FAIL reset_game_done: got %b required 0", game_done); else passed++;
        @(negedge clk); reset = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b required 0", busy); else passed++;
        checks++; if (step_done !== 1'b0) $display("FAIL reset_step_done: got %b required 0", step_done); else passed++;
        checks++; if (head_x !== 32'd4 || head_y !== 32'd4) $display("FAIL reset_head: got (%0d,%0d) required (4,4)", head_x, head_y); else passed++;
        checks++; if (x_values[32*99 +: 32] !== 32'hFFFFFFFF) $display("FAIL reset_slot99: got %h required ffffffff", x_values[32*99 +: 32]); else passed++;
    endtask

    task automatic test_single_step();
        int o, lat, obs; logic b0;
        do_move(2'd1, o, lat, obs, b0);
        checks++; if (obs !== 2) $display("FAIL step_latency: got %0d required 2", obs); else passed++;
        checks++; if (b0 !== 1'b1) $display("FAIL step_busy: got %b required 1", b0); else passed++;
        checks++; if (x_values !== exp_bus(1) || y_values !== exp_bus(0)) $display("FAIL step_bus: got x %h required %h", x_values[95:0], exp_bus(1)); else passed++;
        checks++; if (head_x !== 32'd5 || x_values[63:32] !== 32'd4 || x_values[95:64] !== 32'hFFFFFFFF) $display("FAIL step_slots: got head %0d slot1 %0d slot2 %h", head_x, x_values[63:32], x_values[95:64]); else passed++;
        @(negedge clk);
        checks++; if (step_done !== 1'b0 || busy !== 1'b0) $display("FAIL step_done_fall: got step_done %b busy %b required 0 0", step_done, busy); else passed++;
    endtask

    task automatic test_grow();
        int o, lat, obs; logic b0;
        do_restart();
        pulse_grow();
        pulse_grow();
        do_move(2'd0, o, lat, obs, b0);
        checks++; if (obs !== lat || obs !== 3) $display("FAIL grow_latency: got %0d required %0d", obs, lat); else passed++;
        checks++; if (length !== 32'd3) $display("FAIL grow_length: got %0d required 3", length); else passed++;
        checks++; if (x_values !== exp_bus(1) || y_values !== exp_bus(0)) $display("FAIL grow_bus: got y %h required %h", y_values[95:0], exp_bus(0)); else passed++;
        checks++; if (head_y !== 32'd3 || x_values[95:64] !== 32'd3) $display("FAIL grow_segs: got head_y %0d tail_x %0d required 3 3", head_y, x_values[95:64]); else passed++;
    endtask

    task automatic test_reversal();
        int o, lat, obs; logic b0;
        do_restart();
        do_move(2'd3, o, lat, obs, b0);
        checks++; if (obs !== lat) $display("FAIL reversal_latency: got %0d required %0d", obs, lat); else passed++;
        checks++; if (head_x !== 32'd5 || head_y !== 32'd4) $display("FAIL reversal_head: got (%0d,%0d) required (5,4)", head_x, head_y); else passed++;
    endtask

    task automatic test_wall();
        int o, lat, obs; logic b0;
        do_restart();
        for (int s = 1; s <= 7; s++) begin
            do_move(2'd1, o, lat, obs, b0);
            checks++; if (obs !== lat) $display("FAIL wall_latency_%0d: got %0d required %0d", s, obs, lat); else passed++;
            checks++; if (x_values !== exp_bus(1)) $display("FAIL wall_bus_%0d: got %h required %h", s, x_values[63:0], exp_bus(1)); else passed++;
        end
        checks++; if (game_done !== 1'b1 || b0 !== 1'b0) $display("FAIL wall_hit: got game_done %b busy %b required 1 0", game_done, b0); else passed++;
        checks++; if (head_x !== 32'd9) $display("FAIL wall_head: got %0d required 9", head_x); else passed++;
        pulse_grow();
        do_move(2'd2, o, lat, obs, b0);
        repeat (4) @(negedge clk);
        checks++; if (x_values !== exp_bus(1) || y_values !== exp_bus(0) || length !== 32'd2) $display("FAIL dead_frozen: got head (%0d,%0d) length %0d", head_x, head_y, length); else passed++;
        checks++; if (game_done !== 1'b1 || busy !== 1'b0) $display("FAIL dead_hold: got game_done %b busy %b required 1 0", game_done, busy); else passed++;
    endtask

    task automatic test_self_hit();
        int o, lat, obs; logic b0;
        logic [1:0] turns [3];
        turns[0] = 2'd0; turns[1] = 2'd3; turns[2] = 2'd2;
        do_restart();
        for (int s = 0; s < 3; s++) begin
            pulse_grow();
            do_move(2'd1, o, lat, obs, b0);
        end
        checks++; if (length !== 32'd5) $display("FAIL self_build_length: got %0d required 5", length); else passed++;
        for (int s = 0; s < 3; s++) begin
            do_move(turns[s], o, lat, obs, b0);
            checks++; if (obs !== lat) $display("FAIL self_latency_%0d: got %0d required %0d", s, obs, lat); else passed++;
        end
        checks++; if (obs !== 4 || game_done !== 1'b1) $display("FAIL self_hit: got edge %0d game_done %b required 4 1", obs, game_done); else passed++;
        checks++; if (x_values !== exp_bus(1) || y_values !== exp_bus(0)) $display("FAIL self_frozen: got head (%0d,%0d)", head_x, head_y); else passed++;
    endtask

    task automatic test_restart_mid_scan();
        int o, lat, obs, seen; logic b0;
        do_restart();
        for (int s = 0; s < 2; s++) begin
            pulse_grow();
            do_move(2'd1, o, lat, obs, b0);
        end
        @(negedge clk); dir = 2'd1; step = 1'b1;
        @(negedge clk); step = 1'b0;
        checks++; if (busy !== 1'b1) $display("FAIL abort_busy: got %b required 1", busy); else passed++;
        @(negedge clk); restart = 1'b1;
        @(negedge clk); restart = 1'b0;
        model_init();
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            if (step_done) seen++;
            @(negedge clk);
        end
        checks++; if (seen !== 0) $display("FAIL abort_step_done: got %0d pulses required 0", seen); else passed++;
        checks++; if (x_values !== exp_bus(1) || y_values !== exp_bus(0)) $display("FAIL abort_bus: got head (%0d,%0d) required (4,4)", head_x, head_y); else passed++;
        checks++; if (length !== 32'd2 || busy !== 1'b0 || game_done !== 1'b0) $display("FAIL abort_ctrl: got length %0d busy %b game_done %b", length, busy, game_done); else passed++;
    endtask

    task automatic test_step_while_busy();
        int o, lat, obs, k; logic b0;
        do_restart();
        model_step(2'd1, o, lat);
        @(negedge clk); dir = 2'd1; step = 1'b1;
        @(negedge clk); dir = 2'd0; step = 1'b1;
        @(negedge clk); step = 1'b0;
        k = 0;
        while (!step_done && k < 20) begin
            @(negedge clk);
            k++;
        end
        checks++; if (step_done !== 1'b1) $display("FAIL busy_commit: got step_done %b required 1", step_done); else passed++;
        repeat (5) @(negedge clk);
        checks++; if (x_values !== exp_bus(1) || y_values !== exp_bus(0) || busy !== 1'b0) $display("FAIL busy_dropped: got head (%0d,%0d) busy %b", head_x, head_y, busy); else passed++;
        do_move(2'd3, o, lat, obs, b0);
        checks++; if (obs !== lat || head_x !== 32'd6 || head_y !== 32'd4) $display("FAIL busy_dir_kept: got head (%0d,%0d) edge %0d required (6,4) %0d", head_x, head_y, obs, lat); else passed++;
    endtask

    task automatic test_random();
        int o, lat, obs; logic b0;
        do_restart();
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(2) == 0) pulse_grow();
            do_move(2'($urandom_range(3)), o, lat, obs, b0);
            checks++; if (obs !== lat) $display("FAIL rand_latency_%0d: got %0d required %0d", n, obs, lat); else passed++;
            checks++; if (x_values !== exp_bus(1) || y_values !== exp_bus(0)) $display("FAIL rand_bus_%0d: got head (%0d,%0d) required (%0d,%0d)", n, head_x, head_y, mq_x[0], mq_y[0]); else passed++;
            checks++; if (length !== 32'(mq_x.size()) || game_done !== (o == 1)) $display("FAIL rand_state_%0d: got length %0d game_done %b required %0d %b", n, length, game_done, mq_x.size(), o == 1); else passed++;
            if (m_dead) do_restart();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0; passed = 0;
        reset = 1'b1; step = 1'b0; grow = 1'b0; restart = 1'b0; dir = 2'd1;
        model_init();
        test_reset();
        test_single_step();
        test_grow();
        test_reversal();
        test_wall();
        test_self_hit();
        test_restart_mid_scan();
        test_step_while_busy();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
